btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 144 ++++++++++++++
 tb/tb_btn_conditioner.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Two-channel push-button conditioner: each raw button is synchronized, debounced,
// and turned into a one-cycle press strobe (with optional auto-repeat) and a toggle level.
module btn_conditioner #(
  parameter int DEB_CNT    = 1000000,
  parameter int REPEAT_CNT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic split,
  output logic shift_pulse,
  output logic split_pulse,
  output logic shift_mode,
  output logic split_mode,
  output logic shift_held,
  output logic split_held
);

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  // The accept transition fires on the sample that would bring the count to DEB_CNT-1.
  localparam logic [19:0] DEB_LAST = 20'(DEB_CNT - 2);
  localparam bit          REP_EN   = (REPEAT_CNT != 0);
  localparam logic [23:0] REP_LAST = REP_EN ? 24'(REPEAT_CNT - 1) : 24'd0;

  logic [1:0] raw_vec;
  logic [1:0] pulse_vec;
  logic [1:0] mode_vec;
  logic [1:0] held_vec;

  assign raw_vec = {split, shift};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic        sync1_q;
      logic        s_q;
      state_t      state_q, state_d;
      logic [19:0] cnt_q, cnt_d;
      logic [23:0] rep_q, rep_d;
      logic        pulse_q, pulse_d;
      logic        mode_q, mode_d;
      logic        held_q, held_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        pulse_d = 1'b0;
        case (state_q)
          REL: begin
            if (s_q) begin
              state_d = PRESS_CHK;
              cnt_d   = '0;
            end
          end
          PRESS_CHK: begin
            if (!s_q) begin
              state_d = REL;
              cnt_d   = '0;
            end else if (cnt_q >= DEB_LAST) begin
              state_d = HELD;
              cnt_d   = '0;
              rep_d   = '0;
              pulse_d = 1'b1;
            end else begin
              cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;
            end
          end
          HELD: begin
            if (!s_q) begin
              state_d = REL_CHK;
              cnt_d   = '0;
            end else if (REP_EN) begin
              if (rep_q >= REP_LAST) begin
                rep_d   = '0;
                pulse_d = 1'b1;
              end else begin
                rep_d = (rep_q == '1) ? rep_q : rep_q + 24'd1;
              end
            end
          end
          REL_CHK: begin
            // A bounce back to 1 restarts the repeat period from scratch.
            if (s_q) begin
              state_d = HELD;
              cnt_d   = '0;
              rep_d   = '0;
            end else if (cnt_q >= DEB_LAST) begin
              state_d = REL;
              cnt_d   = '0;
            end else begin
              cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;
            end
          end
          default: begin
            state_d = REL;
            cnt_d   = '0;
          end
        endcase
        held_d = (state_d == HELD) || (state_d == REL_CHK);
        mode_d = mode_q ^ pulse_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q <= 1'b0;
          s_q     <= 1'b0;
          state_q <= REL;
          cnt_q   <= '0;
          rep_q   <= '0;
          pulse_q <= 1'b0;
          mode_q  <= 1'b0;
          held_q  <= 1'b0;
        end else begin
          sync1_q <= raw_vec[gi];
          s_q     <= sync1_q;
          state_q <= state_d;
          cnt_q   <= cnt_d;
          rep_q   <= rep_d;
          pulse_q <= pulse_d;
          mode_q  <= mode_d;
          held_q  <= held_d;
        end
      end

      assign pulse_vec[gi] = pulse_q;
      assign mode_vec[gi]  = mode_q;
      assign held_vec[gi]  = held_q;
    end
  endgenerate

  assign shift_pulse = pulse_vec[0];
  assign split_pulse = pulse_vec[1];
  assign shift_mode  = mode_vec[0];
  assign split_mode  = mode_vec[1];
  assign shift_held  = held_vec[0];
  assign split_held  = held_vec[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: two instances (no repeat / repeat every 8) share the button
// inputs and are compared every cycle against a run-length reference model plus directed checks.
module tb_btn_conditioner;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shift = 1'b0;
  logic split = 1'b0;
  logic [1:0] pulse0, mode0, held0;
  logic [1:0] pulse8, mode8, held8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.DEB_CNT(DEB), .REPEAT_CNT(0)) dut0 (
    .clk(clk), .rst(rst), .shift(shift), .split(split),
    .shift_pulse(pulse0[0]), .split_pulse(pulse0[1]),
    .shift_mode(mode0[0]), .split_mode(mode0[1]),
    .shift_held(held0[0]), .split_held(held0[1])
  );

  btn_conditioner #(.DEB_CNT(DEB), .REPEAT_CNT(8)) dut8 (
    .clk(clk), .rst(rst), .shift(shift), .split(split),
    .shift_pulse(pulse8[0]), .split_pulse(pulse8[1]),
    .shift_mode(mode8[0]), .split_mode(mode8[1]),
    .shift_held(held8[0]), .split_held(held8[1])
  );

  // Reference model, index [instance][channel]: the synchronized sample is the raw input
  // two edges old; the level flips after DEB consecutive samples that disagree with it.
  logic [1:0] m_d1[2], m_d2[2], m_lvl[2], m_brk[2], m_pulse[2], m_mode[2];
  int m_run[2][2];
  int m_hrun[2][2];

  initial begin
    bit rawv, s, p;
    int rc;
    for (int d = 0; d < 2; d++) begin
      m_d1[d] = '0; m_d2[d] = '0; m_lvl[d] = '0; m_brk[d] = '0;
      m_pulse[d] = '0; m_mode[d] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        rc = (d == 0) ? 0 : 8;
        for (int c = 0; c < 2; c++) begin
          rawv = (c == 0) ? shift : split;
          if (rst) begin
            m_d1[d][c] = 0; m_d2[d][c] = 0; m_lvl[d][c] = 0; m_brk[d][c] = 0;
            m_pulse[d][c] = 0; m_mode[d][c] = 0; m_run[d][c] = 0; m_hrun[d][c] = 0;
          end else begin
            s = m_d2[d][c];
            m_d2[d][c] = m_d1[d][c];
            m_d1[d][c] = rawv;
            p = 0;
            if (s != m_lvl[d][c]) begin
              if (!s) m_brk[d][c] = 1;
              m_run[d][c]++;
              if (m_run[d][c] == DEB) begin
                m_lvl[d][c] = s;
                m_run[d][c] = 0;
                if (s) begin
                  p = 1;
                  m_hrun[d][c] = 0;
                  m_brk[d][c] = 0;
                end
              end
            end else begin
              m_run[d][c] = 0;
              if (m_lvl[d][c]) begin
                if (m_brk[d][c]) begin
                  m_brk[d][c] = 0;
                  m_hrun[d][c] = 0;
                end else if (rc > 0) begin
                  m_hrun[d][c]++;
                  if (m_hrun[d][c] == rc) begin
                    p = 1;
                    m_hrun[d][c] = 0;
                  end
                end
              end
            end
            m_mode[d][c] = m_mode[d][c] ^ m_pulse[d][c];
            m_pulse[d][c] = p;
          end
        end
      end
    end
  end

  // Every-cycle scoreboard against the model, plus the no-back-to-back-pulse rule.
  initial begin
    logic [11:0] act, exp_v;
    logic [1:0] prev0, prev8;
    prev0 = '0;
    prev8 = '0;
    forever begin
      @(negedge clk);
      act   = {pulse0, mode0, held0, pulse8, mode8, held8};
      exp_v = {m_pulse[0], m_mode[0], m_lvl[0], m_pulse[1], m_mode[1], m_lvl[1]};
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL model_cmp cyc=%0d actual=%b expected=%b", cyc, act, exp_v);
      end
      checks++;
      if (((pulse0 & prev0) != 2'b00) || ((pulse8 & prev8) != 2'b00)) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d actual=%b_%b expected=no consecutive pulses", cyc, pulse0, pulse8);
      end
      prev0 = pulse0;
      prev8 = pulse8;
    end
  end

  task automatic test_reset();
    rst = 1'b1; shift = 1'b1; split = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pulse0, mode0, held0, pulse8, mode8, held8} !== 12'b0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b expected=0", {pulse0, mode0, held0, pulse8, mode8, held8});
    end
    shift = 1'b0; split = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    int k, pcnt, pedge, mode_at, mode_after;
    pcnt = 0; pedge = -1; mode_at = -1; mode_after = -1;
    shift = 1'b1;
    k = cyc + 1;
    repeat (30) begin
      @(negedge clk);
      if (pedge >= 0 && cyc == pedge + 1) mode_after = int'(mode0[0]);
      if (pulse0[0]) begin
        pcnt++;
        if (pedge < 0) begin
          pedge = cyc;
          mode_at = int'(mode0[0]);
        end
      end
    end
    checks++;
    if (pedge != k + DEB + 1) begin
      failures++;
      $display("FAIL press_latency actual=%0d expected=%0d", pedge - k, DEB + 1);
    end
    checks++;
    if (pcnt != 1) begin
      failures++;
      $display("FAIL press_pulse_count actual=%0d expected=1", pcnt);
    end
    checks++;
    if (mode_at != 0 || mode_after != 1) begin
      failures++;
      $display("FAIL press_mode_timing actual=%0d,%0d expected=0,1", mode_at, mode_after);
    end
    checks++;
    if (held0[0] !== 1'b1 || mode0[0] !== 1'b1) begin
      failures++;
      $display("FAIL press_held_mode actual=%b%b expected=11", held0[0], mode0[0]);
    end
    shift = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    $display("test_clean_press pulse_edge=%0d start_edge=%0d", pedge, k);
  endtask

  task automatic test_bounce();
    int pat[5] = '{1, 0, 1, 1, 0};
    int k, pcnt, pedge;
    pcnt = 0; pedge = -1;
    for (int i = 0; i < 5; i++) begin
      shift = pat[i][0];
      @(negedge clk);
      if (pulse0[0]) pcnt++;
    end
    shift = 1'b1;
    k = cyc + 1;
    repeat (25) begin
      @(negedge clk);
      if (pulse0[0]) begin
        pcnt++;
        if (pedge < 0) pedge = cyc;
      end
    end
    checks++;
    if (pcnt != 1) begin
      failures++;
      $display("FAIL bounce_pulse_count actual=%0d expected=1", pcnt);
    end
    checks++;
    if (pedge != k + DEB + 1) begin
      failures++;
      $display("FAIL bounce_latency actual=%0d expected=%0d", pedge - k, DEB + 1);
    end
    shift = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    $display("test_bounce pulses=%0d", pcnt);
  endtask

  task automatic test_glitch();
    int pcnt;
    pcnt = 0;
    for (int i = 0; i < 100; i++) begin
      split = (i % 3 == 0);
      @(negedge clk);
      if (pulse0[1] || pulse8[1]) pcnt++;
    end
    split = 1'b0;
    checks++;
    if (pcnt != 0) begin
      failures++;
      $display("FAIL glitch_pulses actual=%0d expected=0", pcnt);
    end
    checks++;
    if (mode0[1] !== 1'b0 || mode8[1] !== 1'b0 || held0[1] !== 1'b0) begin
      failures++;
      $display("FAIL glitch_mode actual=%b%b%b expected=000", mode0[1], mode8[1], held0[1]);
    end
    repeat (DEB + 4) @(negedge clk);
    $display("test_glitch pulses=%0d", pcnt);
  endtask

  task automatic test_repeat();
    int e, k, p0cnt, hedge, relcnt;
    int q[$];
    e = -1; p0cnt = 0; hedge = -1; relcnt = 0;
    shift = 1'b1;
    for (int i = 0; i < 20 && e < 0; i++) begin
      @(negedge clk);
      if (pulse8[0]) e = cyc;
    end
    checks++;
    if (e < 0) begin
      failures++;
      $display("FAIL repeat_accept_timeout actual=none expected=pulse within 20 cycles");
    end
    repeat (40) begin
      @(negedge clk);
      if (pulse8[0]) q.push_back(cyc);
      if (pulse0[0]) p0cnt++;
    end
    checks++;
    if (q.size() != 5) begin
      failures++;
      $display("FAIL repeat_count actual=%0d expected=5", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i] != e + 8 * (i + 1)) begin
        failures++;
        $display("FAIL repeat_spacing idx=%0d actual=%0d expected=%0d", i, q[i] - e, 8 * (i + 1));
      end
    end
    checks++;
    if (p0cnt != 0) begin
      failures++;
      $display("FAIL norepeat_pulses actual=%0d expected=0", p0cnt);
    end
    shift = 1'b0;
    k = cyc + 1;
    repeat (15) begin
      @(negedge clk);
      if (pulse8[0]) relcnt++;
      if (hedge < 0 && held8[0] === 1'b0) hedge = cyc;
    end
    checks++;
    if (relcnt != 0) begin
      failures++;
      $display("FAIL release_pulses actual=%0d expected=0", relcnt);
    end
    checks++;
    if (hedge != k + DEB + 1) begin
      failures++;
      $display("FAIL release_latency actual=%0d expected=%0d", hedge - k, DEB + 1);
    end
    $display("test_repeat accept=%0d repeats=%0d held_fall=%0d", e, q.size(), hedge);
  endtask

  task automatic test_simultaneous();
    int e_sh, e_sp;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int round = 0; round < 2; round++) begin
      e_sh = -1; e_sp = -1;
      shift = 1'b1; split = 1'b1;
      repeat (15) begin
        @(negedge clk);
        if (pulse0[0] && e_sh < 0) e_sh = cyc;
        if (pulse0[1] && e_sp < 0) e_sp = cyc;
      end
      checks++;
      if (e_sh < 0 || e_sh != e_sp) begin
        failures++;
        $display("FAIL simul_pulse_edge round=%0d actual=%0d,%0d expected=equal", round, e_sh, e_sp);
      end
      checks++;
      if (mode0 !== ((round == 0) ? 2'b11 : 2'b00)) begin
        failures++;
        $display("FAIL simul_mode round=%0d actual=%b expected=%b", round, mode0, (round == 0) ? 2'b11 : 2'b00);
      end
      shift = 1'b0; split = 1'b0;
      repeat (DEB + 8) @(negedge clk);
      $display("test_simultaneous round=%0d edges=%0d,%0d mode=%b", round, e_sh, e_sp, mode0);
    end
  endtask

  task automatic test_reset_midpress();
    int pre, r, pcnt, pedge;
    pre = 0; pcnt = 0; pedge = -1;
    shift = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (pulse0[0]) pre++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pulse0, mode0, held0, pulse8, mode8, held8} !== 12'b0 || pre != 0) begin
      failures++;
      $display("FAIL midpress_reset actual=%b pre=%0d expected=0 pre=0", {pulse0, mode0, held0, pulse8, mode8, held8}, pre);
    end
    rst = 1'b0;
    r = cyc + 1;
    repeat (20) begin
      @(negedge clk);
      if (pulse0[0]) begin
        pcnt++;
        if (pedge < 0) pedge = cyc;
      end
    end
    checks++;
    if (pcnt != 1 || pedge != r + DEB + 1) begin
      failures++;
      $display("FAIL midpress_requal actual=%0d@%0d expected=1@%0d", pcnt, pedge - r, DEB + 1);
    end
    shift = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    $display("test_reset_midpress pulse_after=%0d", pedge - r);
  endtask

  task automatic test_random();
    int sh_left, sp_left, npulse;
    sh_left = 0; sp_left = 0; npulse = 0;
    for (int i = 0; i < 3000; i++) begin
      if (sh_left == 0) begin
        shift = 1'($urandom_range(0, 1));
        sh_left = $urandom_range(1, 9);
      end
      if (sp_left == 0) begin
        split = 1'($urandom_range(0, 1));
        sp_left = $urandom_range(1, 9);
      end
      sh_left--;
      sp_left--;
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      if ((pulse0 | pulse8) != 2'b00) npulse++;
    end
    rst = 1'b0;
    checks++;
    if (npulse == 0) begin
      failures++;
      $display("FAIL random_activity actual=0 expected=>0");
    end
    $display("test_random cycles=3000 pulse_cycles=%0d", npulse);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_reset_midpress();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
